// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state enum, opcodes, datapath select codes.
// Pure type/constant package, no logic and no latency.
// No flow control; these are static encodings consumed by the FSM and datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  // RV32I major opcodes handled by this core
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // ALU operand A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU decoder command
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Dispatch target out of DECODE; anything unrecognised parks the core in TRAP.
  function automatic state_t decode_target(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: decode_target = MEMADR;
      OP_R:              decode_target = EXECUTER;
      OP_I:              decode_target = EXECUTEI;
      OP_JAL:            decode_target = JAL;
      OP_BRANCH:         decode_target = BEQ;
      default:           decode_target = TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the RV32I multicycle core: fetch/decode/execute/memory/writeback sequencing.
// Moore outputs straight off the state register; PCWrite alone is combinational on zero. 3-5 cycles per instruction.
// No backpressure: advances one state every clock; an illegal opcode stalls in TRAP until rst.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal
);

  state_t state;
  state_t state_nxt;
  logic   pc_update;
  logic   branch;

  // State register; synchronous reset returns to FETCH from anywhere, including TRAP.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next-state selection and per-state control decode.
  always_comb begin
    state_nxt  = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALUOP_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        // IR <- mem[PC]; PC <- PC + 4 through the ALU result path
        AdrSrc    = 1'b0;
        IRWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALURES;
        pc_update = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        // OldPC + imm is computed speculatively so BEQ finds its target in ALUOut
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALUOP_ADD;
        state_nxt = decode_target(opcode);
      end
      MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALUOP_ADD;
        // Only lw and sw reach here, so anything that is not a load is the store
        state_nxt = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end
      MEMWRITE: begin
        ResultSrc  = RES_ALUOUT;
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end
      EXECUTER: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end
      JAL: begin
        // rd gets OldPC + 4 later in ALUWB while PC takes the target held in ALUOut
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        pc_update = 1'b1;
        state_nxt = ALUWB;
      end
      BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_SUB;
        ResultSrc  = RES_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_nxt  = FETCH;
      end
      TRAP: begin
        illegal   = 1'b1;
        state_nxt = TRAP;
      end
      default: begin
        // Unused encodings recover through a fresh fetch
        state_nxt = FETCH;
      end
    endcase
  end

  // Branch is taken in the same cycle the comparison produces zero.
  assign PCWrite = pc_update | (branch & zero);

endmodule
